// File: rtl/lsu_dados_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dados_pkg
//  Description : Shared types and memory geometry for the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_dados_pkg;

    localparam int MEM_WORDS = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Unsigned compare on the full address width, so huge addresses never alias.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       words);
        return addr < ADDR_W'(words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dados_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dados_if / lsu_dados_mem_if
//  Description : Processor request/response channel and data-memory bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_dados_if
    import lsu_dados_pkg::*;
#(
    parameter int DW = DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface lsu_dados_mem_if
    import lsu_dados_pkg::*;
#(
    parameter int DW = DATA_W
);
    logic [ADDR_W-1:0] mem_address;
    logic [DW-1:0]     mem_wdata;
    logic              mem_write;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output mem_address, mem_wdata, mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_address, mem_wdata, mem_write,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dados_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/lsu_dados.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dados
//  Description : Single-outstanding load/store initiator with debug counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dados
    import lsu_dados_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    lsu_dados_if.slave       cpu,
    lsu_dados_mem_if.master  mem,
    output logic [CNT_W-1:0] cnt_loads,
    output logic [CNT_W-1:0] cnt_stores,
    output logic [CNT_W-1:0] cnt_errs
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic w_accept;
    logic w_in_range;
    logic w_inc_load;
    logic w_inc_store;
    logic w_inc_err;

    assign w_accept    = (r_state == ST_IDLE) && cpu.req_valid;
    assign w_in_range  = addr_in_range(cpu.req_addr, MEM_WORDS);
    assign w_inc_load  = (r_state == ST_ACCESS) && !r_we;
    assign w_inc_store = (r_state == ST_ACCESS) &&  r_we;
    assign w_inc_err   = w_accept && !w_in_range;

    // mem_write is a flop so the memory never sees a combinational glitch;
    // the async reset drops it mid-ACCESS, aborting the store cleanly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_mem_write <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu.req_valid) begin
                        r_addr  <= cpu.req_addr;
                        r_wdata <= cpu.req_wdata;
                        r_we    <= cpu.req_we;
                        if (w_in_range) begin
                            r_mem_write <= cpu.req_we;
                            r_state     <= ST_ACCESS;
                        end else begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_rsp_data <= r_we ? '0 : mem.mem_rdata;
                    r_rsp_err  <= 1'b0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (cpu.rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu.req_ready   = (r_state == ST_IDLE);
    assign cpu.rsp_valid   = (r_state == ST_RESP);
    assign cpu.rsp_data    = r_rsp_data;
    assign cpu.rsp_err     = r_rsp_err;

    assign mem.mem_address = r_addr;
    assign mem.mem_wdata   = r_wdata;
    assign mem.mem_write   = r_mem_write;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_loads (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_inc_load),
        .count   (cnt_loads)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stores (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_inc_store),
        .count   (cnt_stores)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_errs (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_inc_err),
        .count   (cnt_errs)
    );

endmodule
`default_nettype wire

// File: tb/tb_lsu_dados.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_dados
//  Description : Directed + random bench for lsu_dados against a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dados;

    localparam int MW = lsu_dados_pkg::MEM_WORDS;
    localparam int DW = lsu_dados_pkg::DATA_W;
    localparam int AW = $clog2(MW);

    logic clock     = 1'b0;
    logic reset_n   = 1'b0;
    logic mem_clear = 1'b0;

    always #5 clock = ~clock;

    lsu_dados_if     cpu ();
    lsu_dados_if     cpu_s ();
    lsu_dados_mem_if mbus ();
    lsu_dados_mem_if mbus_s ();

    logic [15:0] cnt_loads, cnt_stores, cnt_errs;
    logic [3:0]  s_loads, s_stores, s_errs;

    lsu_dados #(.CNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu        (cpu),
        .mem        (mbus),
        .cnt_loads  (cnt_loads),
        .cnt_stores (cnt_stores),
        .cnt_errs   (cnt_errs)
    );

    // Narrow-counter copy runs in lockstep on the same request stream.
    lsu_dados #(.CNT_W(4)) dut_sat (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu        (cpu_s),
        .mem        (mbus_s),
        .cnt_loads  (s_loads),
        .cnt_stores (s_stores),
        .cnt_errs   (s_errs)
    );

    assign cpu_s.req_valid = cpu.req_valid;
    assign cpu_s.req_we    = cpu.req_we;
    assign cpu_s.req_addr  = cpu.req_addr;
    assign cpu_s.req_wdata = cpu.req_wdata;
    assign cpu_s.rsp_ready = cpu.rsp_ready;

    // Data memories: combinational read, write on the rising edge.
    logic [DW-1:0] mem_arr   [MW];
    logic [DW-1:0] mem_arr_s [MW];

    assign mbus.mem_rdata   = (mbus.mem_address < 32'(MW))   ? mem_arr[mbus.mem_address[AW-1:0]]     : '0;
    assign mbus_s.mem_rdata = (mbus_s.mem_address < 32'(MW)) ? mem_arr_s[mbus_s.mem_address[AW-1:0]] : '0;

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < MW; i++) begin
                mem_arr[i]   <= '0;
                mem_arr_s[i] <= '0;
            end
        end else begin
            if (mbus.mem_write && (mbus.mem_address < 32'(MW)))
                mem_arr[mbus.mem_address[AW-1:0]] <= mbus.mem_wdata;
            if (mbus_s.mem_write && (mbus_s.mem_address < 32'(MW)))
                mem_arr_s[mbus_s.mem_address[AW-1:0]] <= mbus_s.mem_wdata;
        end
    end

    // Reference model: word memory contents and completed-access tallies.
    logic [DW-1:0] ref_mem [MW];
    int n_loads, n_stores, n_errs;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (longint'(n) > lim) ? 64'(lim) : 64'(n);
    endfunction

    task automatic check_counters();
        chk("cnt_loads",    64'(cnt_loads),  sat(n_loads, 16));
        chk("cnt_stores",   64'(cnt_stores), sat(n_stores, 16));
        chk("cnt_errs",     64'(cnt_errs),   sat(n_errs, 16));
        chk("sat_loads",    64'(s_loads),    sat(n_loads, 4));
        chk("sat_stores",   64'(s_stores),   sat(n_stores, 4));
        chk("sat_errs",     64'(s_errs),     sat(n_errs, 4));
    endtask

    // One full request; entered and left 1 time unit after a rising edge with the DUT idle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata, input int hold);
        logic          err;
        logic [DW-1:0] exp_data;
        err      = (addr >= 32'(MW));
        exp_data = (err || we) ? '0 : ref_mem[addr[AW-1:0]];

        cpu.req_valid = 1'b1;
        cpu.req_we    = we;
        cpu.req_addr  = addr;
        cpu.req_wdata = wdata;
        cpu.rsp_ready = (hold == 0);
        chk("req_ready_idle", 64'(cpu.req_ready), 64'(1));
        @(posedge clock); #1;
        cpu.req_valid = 1'b0;
        cpu.req_we    = 1'($urandom);
        cpu.req_addr  = $urandom;
        cpu.req_wdata = $urandom;

        if (!err) begin
            chk("access_rsp_valid", 64'(cpu.rsp_valid),     64'(0));
            chk("access_req_ready", 64'(cpu.req_ready),     64'(0));
            chk("access_mem_write", 64'(mbus.mem_write),    64'(we));
            chk("access_mem_addr",  64'(mbus.mem_address),  64'(addr));
            if (we) chk("access_mem_wdata", 64'(mbus.mem_wdata), 64'(wdata));
            @(posedge clock); #1;
        end

        chk("rsp_valid",     64'(cpu.rsp_valid),  64'(1));
        chk("rsp_err",       64'(cpu.rsp_err),    64'(err));
        chk("rsp_data",      64'(cpu.rsp_data),   64'(exp_data));
        chk("rsp_mem_write", 64'(mbus.mem_write), 64'(0));
        chk("rsp_req_ready", 64'(cpu.req_ready),  64'(0));

        if (err)      n_errs++;
        else if (we) begin
            n_stores++;
            ref_mem[addr[AW-1:0]] = wdata;
        end else      n_loads++;

        for (int c = 0; c < hold; c++) begin
            cpu.req_valid = 1'b1;
            cpu.req_we    = 1'b0;
            cpu.req_addr  = 32'($urandom_range(0, MW - 1));
            @(posedge clock); #1;
            chk("hold_rsp_valid", 64'(cpu.rsp_valid),  64'(1));
            chk("hold_rsp_data",  64'(cpu.rsp_data),   64'(exp_data));
            chk("hold_rsp_err",   64'(cpu.rsp_err),    64'(err));
            chk("hold_req_ready", 64'(cpu.req_ready),  64'(0));
            chk("hold_mem_write", 64'(mbus.mem_write), 64'(0));
        end

        cpu.rsp_ready = 1'b1;
        @(posedge clock); #1;
        chk("done_rsp_valid", 64'(cpu.rsp_valid),  64'(0));
        chk("done_req_ready", 64'(cpu.req_ready),  64'(1));
        chk("done_mem_write", 64'(mbus.mem_write), 64'(0));
        cpu.req_valid = 1'b0;
        check_counters();
    endtask

    logic [31:0]   taddr [8];
    logic [DW-1:0] tdata [8];
    logic [31:0]   raddr;
    int issued, seen, pulses, cyc, sel;
    logic prev_w;
    bit   done;

    initial begin
        cpu.req_valid = 1'b0;
        cpu.req_we    = 1'b0;
        cpu.req_addr  = '0;
        cpu.req_wdata = '0;
        cpu.rsp_ready = 1'b1;
        for (int i = 0; i < MW; i++) ref_mem[i] = '0;
        n_loads = 0; n_stores = 0; n_errs = 0;

        // Reset state, memory cleared while reset is held.
        mem_clear = 1'b1;
        @(posedge clock); #1;
        mem_clear = 1'b0;
        chk("rst_req_ready", 64'(cpu.req_ready),     64'(1));
        chk("rst_rsp_valid", 64'(cpu.rsp_valid),     64'(0));
        chk("rst_rsp_data",  64'(cpu.rsp_data),      64'(0));
        chk("rst_rsp_err",   64'(cpu.rsp_err),       64'(0));
        chk("rst_mem_addr",  64'(mbus.mem_address),  64'(0));
        chk("rst_mem_wdata", 64'(mbus.mem_wdata),    64'(0));
        chk("rst_mem_write", 64'(mbus.mem_write),    64'(0));
        check_counters();
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // Store then load.
        txn(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'd5, 32'h0, 0);

        // Range boundary.
        txn(1'b1, 32'd31, 32'hCAFE_F00D, 0);
        txn(1'b0, 32'd31, 32'h0, 0);
        txn(1'b0, 32'd32, 32'h0, 0);
        txn(1'b0, 32'hFFFF_FFFF, 32'h0, 0);
        chk("boundary_errs", 64'(cnt_errs), 64'(2));

        // Response backpressure with a competing request.
        txn(1'b1, 32'd3, 32'h0000_1234, 0);
        txn(1'b0, 32'd3, 32'h0, 10);

        // Reset asynchronously in the middle of a store to address 7.
        txn(1'b1, 32'd7, 32'h1111_2222, 0);
        cpu.req_valid = 1'b1;
        cpu.req_we    = 1'b1;
        cpu.req_addr  = 32'd7;
        cpu.req_wdata = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        cpu.req_valid = 1'b0;
        chk("abort_pre_write", 64'(mbus.mem_write), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mem_write", 64'(mbus.mem_write),   64'(0));
        chk("abort_rsp_valid", 64'(cpu.rsp_valid),    64'(0));
        chk("abort_req_ready", 64'(cpu.req_ready),    64'(1));
        chk("abort_mem_addr",  64'(mbus.mem_address), 64'(0));
        chk("abort_mem_wdata", 64'(mbus.mem_wdata),   64'(0));
        chk("abort_rsp_data",  64'(cpu.rsp_data),     64'(0));
        chk("abort_rsp_err",   64'(cpu.rsp_err),      64'(0));
        n_loads = 0; n_stores = 0; n_errs = 0;
        check_counters();
        @(posedge clock); #1;
        chk("abort_no_rsp", 64'(cpu.rsp_valid), 64'(0));
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        txn(1'b0, 32'd7, 32'h0, 0);

        // Throughput: eight stores with request and response held open.
        for (int k = 0; k < 8; k++) begin
            taddr[k] = 32'(k * 3 + 1);
            tdata[k] = $urandom;
        end
        issued = 0; seen = 0; pulses = 0; cyc = 0; prev_w = 1'b0; done = 1'b0;
        cpu.rsp_ready = 1'b1;
        cpu.req_we    = 1'b1;
        while (!done && cyc < 100) begin
            if (cpu.req_ready) begin
                if (issued < 8) begin
                    cpu.req_valid = 1'b1;
                    cpu.req_addr  = taddr[issued];
                    cpu.req_wdata = tdata[issued];
                    issued++;
                end else begin
                    cpu.req_valid = 1'b0;
                    done = 1'b1;
                end
            end
            if (!done) begin
                @(posedge clock); #1;
                cyc++;
                if (mbus.mem_write) begin
                    pulses++;
                    chk("tp_pulse_width", 64'(prev_w), 64'(0));
                    if (seen < 8) begin
                        chk("tp_addr", 64'(mbus.mem_address), 64'(taddr[seen]));
                        chk("tp_data", 64'(mbus.mem_wdata),   64'(tdata[seen]));
                        ref_mem[taddr[seen][AW-1:0]] = tdata[seen];
                        n_stores++;
                        seen++;
                    end
                end
                prev_w = mbus.mem_write;
            end
        end
        cpu.req_valid = 1'b0;
        chk("tp_cycles", 64'(cyc),    64'(24));
        chk("tp_pulses", 64'(pulses), 64'(8));
        check_counters();
        for (int k = 0; k < 8; k++) txn(1'b0, taddr[k], 32'h0, 0);

        // Randomized mix including out-of-range and boundary addresses.
        repeat (30) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       raddr = 32'(MW);
                1:       raddr = 32'hFFFF_FFFF;
                2:       raddr = $urandom | 32'h8000_0000;
                3:       raddr = 32'(MW - 1);
                default: raddr = 32'($urandom_range(0, MW - 1));
            endcase
            txn(1'($urandom), raddr, $urandom, $urandom_range(0, 2));
        end

        // Saturation of the narrow counters.
        repeat (20) txn(1'b0, 32'($urandom_range(0, MW - 1)), 32'h0, 0);
        chk("sat_loads_stuck", 64'(s_loads), 64'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
